// File: rtl/adxl362_reader.sv
// adxl362_reader: periodically reads an ADXL362 accelerometer through simple_spi_top
// using Wishbone accesses, and presents sign-extended x/y/z samples with a valid/ready handshake.
// Optional feature: define ADXL362_READER_TEMP_EN to extend the burst and read the temperature pair.
module adxl362_reader #(
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter logic [7:0]  SPCR_INIT     = 8'h50
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  output logic [1:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  output logic        ncs_o,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic [15:0] z_o,
`ifdef ADXL362_READER_TEMP_EN
  output logic [15:0] temp_o,
`endif
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = 24;
`ifdef ADXL362_READER_TEMP_EN
  localparam int unsigned NBYTES = 10;
`else
  localparam int unsigned NBYTES = 8;
`endif
  localparam int unsigned NSHADOW = NBYTES - 2;
  localparam int unsigned SH_W    = NSHADOW * 8;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]       LAST_BYTE   = 4'(NBYTES - 1);
  localparam logic [1:0]       ADR_SPCR    = 2'd0;
  localparam logic [1:0]       ADR_SPSR    = 2'd1;
  localparam logic [1:0]       ADR_SPDR    = 2'd2;
  localparam logic [7:0]       CMD_READ    = 8'h0B;
  localparam logic [7:0]       REG_XDATA_L = 8'h0E;

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_CS_ON, S_WR_BYTE, S_POLL, S_RD_BYTE, S_CS_OFF
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              idle_q, idle_d;
  logic [3:0]        byte_q, byte_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [1:0]        adr_d;
  logic [7:0]        dat_d;
  logic              we_d, cyc_d, ncs_d;
  logic [15:0]       x_d, y_d, z_d;
`ifdef ADXL362_READER_TEMP_EN
  logic [15:0]       temp_d;
`endif
  logic              valid_d, overrun_d, busy_d;
  logic              copy;
  logic [7:0]        tx_byte;

  // 12-bit two's complement value from the low byte and the low nibble of the high byte
  function automatic logic [15:0] sext12(input logic [7:0] lo, input logic [7:0] hi);
    return {{4{hi[3]}}, hi[3:0], lo};
  endfunction

  // Next-state, Wishbone sequencing, sample capture and handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    byte_d    = byte_q;
    shadow_d  = shadow_q;
    adr_d     = wb_adr_o;
    dat_d     = wb_dat_o;
    we_d      = wb_we_o;
    cyc_d     = wb_cyc_o;
    ncs_d     = ncs_o;
    x_d       = x_o;
    y_d       = y_o;
    z_d       = z_o;
`ifdef ADXL362_READER_TEMP_EN
    temp_d    = temp_o;
`endif
    valid_d   = sample_valid_o;
    overrun_d = overrun_o;
    copy      = 1'b0;

    case (byte_q)
      4'd0:    tx_byte = CMD_READ;
      4'd1:    tx_byte = REG_XDATA_L;
      default: tx_byte = 8'h00;
    endcase

    // Period counter runs free once initialised so burst starts stay SAMPLE_PERIOD apart
    if (state_q != S_INIT) begin
      if (!enable_i)                cnt_d = '0;
      else if (cnt_q == PERIOD_LAST) cnt_d = '0;
      else                          cnt_d = cnt_q + CNT_W'(1);
    end

    if (sample_valid_o && sample_ready_i) valid_d = 1'b0;

    case (state_q)
      S_INIT: begin
        if (!wb_cyc_o) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SPCR; dat_d = SPCR_INIT;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0; we_d = 1'b0; state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (enable_i && cnt_q == PERIOD_LAST) begin
          state_d = S_CS_ON; ncs_d = 1'b0; idle_d = 1'b0; byte_d = '0;
        end
      end
      S_CS_ON: begin
        if (idle_q) begin
          idle_d = 1'b0; state_d = S_WR_BYTE;
        end else begin
          idle_d = 1'b1;
        end
      end
      S_WR_BYTE: begin
        if (!wb_cyc_o) begin
          cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SPDR; dat_d = tx_byte;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0; we_d = 1'b0; state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (!wb_cyc_o) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_SPSR;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0;
          if (!wb_dat_i[0]) state_d = S_RD_BYTE;
        end
      end
      S_RD_BYTE: begin
        if (!wb_cyc_o) begin
          cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_SPDR;
        end else if (wb_ack_i) begin
          cyc_d = 1'b0;
          for (int unsigned i = 0; i < NSHADOW; i++) begin
            if (byte_q == 4'(i + 2)) shadow_d[i*8 +: 8] = wb_dat_i;
          end
          if (byte_q == LAST_BYTE) begin
            state_d = S_CS_OFF; ncs_d = 1'b1; idle_d = 1'b0;
          end else begin
            byte_d = byte_q + 4'd1; state_d = S_WR_BYTE;
          end
        end
      end
      S_CS_OFF: begin
        if (idle_q) begin
          idle_d = 1'b0; copy = 1'b1; state_d = S_WAIT;
        end else begin
          idle_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Publish the shadow; an unaccepted previous sample is overwritten and flagged
    if (copy) begin
      x_d = sext12(shadow_q[7:0],   shadow_q[15:8]);
      y_d = sext12(shadow_q[23:16], shadow_q[31:24]);
      z_d = sext12(shadow_q[39:32], shadow_q[47:40]);
`ifdef ADXL362_READER_TEMP_EN
      temp_d = sext12(shadow_q[55:48], shadow_q[63:56]);
`endif
      if (sample_valid_o && !sample_ready_i) overrun_d = 1'b1;
      valid_d = 1'b1;
    end

    busy_d = !ncs_d || (state_d == S_INIT);
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= S_INIT;
      cnt_q          <= '0;
      idle_q         <= 1'b0;
      byte_q         <= '0;
      shadow_q       <= '0;
      wb_adr_o       <= '0;
      wb_dat_o       <= '0;
      wb_we_o        <= 1'b0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      ncs_o          <= 1'b1;
      x_o            <= '0;
      y_o            <= '0;
      z_o            <= '0;
`ifdef ADXL362_READER_TEMP_EN
      temp_o         <= '0;
`endif
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idle_q         <= idle_d;
      byte_q         <= byte_d;
      shadow_q       <= shadow_d;
      wb_adr_o       <= adr_d;
      wb_dat_o       <= dat_d;
      wb_we_o        <= we_d;
      wb_cyc_o       <= cyc_d;
      wb_stb_o       <= cyc_d;
      ncs_o          <= ncs_d;
      x_o            <= x_d;
      y_o            <= y_d;
      z_o            <= z_d;
`ifdef ADXL362_READER_TEMP_EN
      temp_o         <= temp_d;
`endif
      sample_valid_o <= valid_d;
      overrun_o      <= overrun_d;
      busy_o         <= busy_d;
    end
  end

endmodule

// File: tb/tb_adxl362_reader.sv
// tb_adxl362_reader: behavioural simple_spi + ADXL362 Wishbone slave, scoreboard of expected samples.
// Define ADXL362_READER_TEMP_EN to exercise the temperature variant.
module tb_adxl362_reader;

  localparam int unsigned PERIOD = 200;
`ifdef ADXL362_READER_TEMP_EN
  localparam int NBYTES = 10;
`else
  localparam int NBYTES = 8;
`endif

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] t;
  } samp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        sample_ready_i = 1'b0;
  logic [1:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [7:0]  rdat;
  logic        ack;
  logic        ncs_o;
  logic [15:0] x_o, y_o, z_o;
`ifdef ADXL362_READER_TEMP_EN
  logic [15:0] temp_o;
`endif
  logic        sample_valid_o, overrun_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc_count = 0;
  int valid_rises = 0;

  samp_t      exp_q[$];
  logic [11:0] mx, my, mz, mt;

  adxl362_reader #(.SAMPLE_PERIOD(PERIOD), .SPCR_INIT(8'h50)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(rdat), .wb_ack_i(ack), .ncs_o(ncs_o),
    .x_o(x_o), .y_o(y_o), .z_o(z_o),
`ifdef ADXL362_READER_TEMP_EN
    .temp_o(temp_o),
`endif
    .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // MISO stream: garbage on command bytes; high bytes carry junk above bit 3 (inverted sign)
  function automatic logic [7:0] miso_byte(input int idx);
    case (idx)
      2:       return mx[7:0];
      3:       return {~mx[11], 3'b010, mx[11:8]};
      4:       return my[7:0];
      5:       return {~my[11], 3'b010, my[11:8]};
      6:       return mz[7:0];
      7:       return {~mz[11], 3'b010, mz[11:8]};
      8:       return mt[7:0];
      9:       return {~mt[11], 3'b010, mt[11:8]};
      default: return 8'hA5;
    endcase
  endfunction

  // Slave model: registered ack, SPDR write queues a MISO byte after a short shift delay
  logic [7:0] rxq[$];
  logic [7:0] mosi_log[$];
  logic [7:0] pend_byte;
  int         pend_cnt;
  logic       ncs_prev;
  logic       got_first;
  logic [1:0] first_adr;
  logic       first_we;
  logic [7:0] first_dat;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      ack       <= 1'b0;
      rdat      <= 8'h00;
      ncs_prev  <= 1'b1;
      rxq.delete();
      pend_cnt  = 0;
      got_first = 1'b0;
    end else begin
      ack <= 1'b0;
      ncs_prev <= ncs_o;
      if (ncs_prev && !ncs_o) mosi_log.delete();
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) rxq.push_back(pend_byte);
      end
      if (wb_cyc_o && wb_stb_o && !ack) begin
        ack <= 1'b1;
        if (!got_first) begin
          got_first = 1'b1;
          first_adr = wb_adr_o;
          first_we  = wb_we_o;
          first_dat = wb_dat_o;
        end
        if (wb_we_o) begin
          if (wb_adr_o == 2'd2) begin
            pend_byte = miso_byte(mosi_log.size());
            mosi_log.push_back(wb_dat_o);
            pend_cnt = 4;
          end
        end else if (wb_adr_o == 2'd1) begin
          rdat <= {7'b0000010, (rxq.size() == 0)};
        end else if (wb_adr_o == 2'd2) begin
          if (rxq.size() > 0) rdat <= rxq.pop_front();
          else                rdat <= 8'h00;
        end
      end
    end
  end

  // Monitor: each newly presented sample is popped from the scoreboard and compared
  logic        pv = 1'b0;
  logic        pacc = 1'b0;
  logic [15:0] px, py, pz;
  samp_t       e;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      pv = 1'b0;
      pacc = 1'b0;
    end else begin
      if (sample_valid_o && (!pv || pacc || x_o != px || y_o != py || z_o != pz)) begin
        if (!pv) valid_rises++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got x=0x%0h y=0x%0h z=0x%0h, expected none", x_o, y_o, z_o);
        end else begin
          e = exp_q.pop_front();
          check("sample_x", 32'(x_o), 32'(e.x));
          check("sample_y", 32'(y_o), 32'(e.y));
          check("sample_z", 32'(z_o), 32'(e.z));
`ifdef ADXL362_READER_TEMP_EN
          check("sample_temp", 32'(temp_o), 32'(e.t));
`endif
        end
      end
      pv   = sample_valid_o;
      pacc = sample_valid_o && sample_ready_i;
      px = x_o; py = y_o; pz = z_o;
    end
  end

  task automatic wait_ncs(input logic lvl, input string name, output int waited);
    waited = 0;
    while (ncs_o !== lvl && waited < 1000) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (ncs_o !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: ncs_o=%b after %0d cycles, expected %b", name, ncs_o, waited, lvl);
    end
  endtask

  task automatic wait_first_access(output int waited);
    waited = 0;
    while (!got_first && waited < 50) begin
      @(posedge clk_i); #1;
      waited++;
    end
    check("init_access_seen", 32'(got_first), 32'd1);
    check("init_adr", 32'(first_adr), 32'd0);
    check("init_we", 32'(first_we), 32'd1);
    check("init_dat", 32'(first_dat), 32'h50);
  endtask

  task automatic do_burst(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z,
                          input logic [11:0] t, input samp_t ex, input logic drop_en,
                          output int fall_at, output int start_wait);
    int n;
    mx = x; my = y; mz = z; mt = t;
    exp_q.push_back(ex);
    wait_ncs(1'b0, "burst_start", start_wait);
    fall_at = cyc_count;
    if (drop_en) begin
      repeat (5) @(posedge clk_i);
      #1 enable_i = 1'b0;
    end
    wait_ncs(1'b1, "burst_end", n);
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n, sw, f1, f2, base, lows;
    logic [7:0] eb;

    rst_i = 1'b0; enable_i = 1'b1; sample_ready_i = 1'b1;
    mx = '0; my = '0; mz = '0; mt = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ncs", 32'(ncs_o), 32'd1);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_adr", 32'(wb_adr_o), 32'd0);
    check("rst_dat", 32'(wb_dat_o), 32'd0);
    check("rst_x", 32'(x_o), 32'd0);
    check("rst_valid", 32'(sample_valid_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);

    @(negedge clk_i) rst_i = 1'b1;
    wait_first_access(n);

    // First burst: ncs must not fall before the period has elapsed
    do_burst(12'h123, 12'hF00, 12'h7FF, 12'h8A0, {16'h0123, 16'hFF00, 16'h07FF, 16'hF8A0}, 1'b0, f1, sw);
    check("first_burst_delay_in_range", 32'((n + sw) >= 200 && (n + sw) <= 210), 32'd1);
    check("mosi_count", 32'(mosi_log.size()), 32'(NBYTES));
    for (int i = 0; i < NBYTES && i < mosi_log.size(); i++) begin
      eb = (i == 0) ? 8'h0B : (i == 1) ? 8'h0E : 8'h00;
      check($sformatf("mosi_byte%0d", i), 32'(mosi_log[i]), 32'(eb));
    end
    check("valid_cleared_after_accept", 32'(sample_valid_o), 32'd0);

    // Ready held high: one pulse per burst, starts exactly PERIOD apart
    base = valid_rises;
    do_burst(12'h800, 12'h001, 12'hFFF, 12'h7F0, {16'hF800, 16'h0001, 16'hFFFF, 16'h07F0}, 1'b0, f1, sw);
    do_burst(12'h07F, 12'h980, 12'h100, 12'h000, {16'h007F, 16'hF980, 16'h0100, 16'h0000}, 1'b0, f2, sw);
    check("burst_interval", 32'(f2 - f1), 32'(PERIOD));
    check("pulses_ready_high", 32'(valid_rises - base), 32'd2);
    check("no_overrun_ready_high", 32'(overrun_o), 32'd0);

    // Ready low across two bursts: second sample overwrites, overrun latches
    sample_ready_i = 1'b0;
    do_burst(12'h7FF, 12'h800, 12'h000, 12'hFFF, {16'h07FF, 16'hF800, 16'h0000, 16'hFFFF}, 1'b0, f1, sw);
    check("no_overrun_first_unaccepted", 32'(overrun_o), 32'd0);
    do_burst(12'h456, 12'hABC, 12'h001, 12'h123, {16'h0456, 16'hFABC, 16'h0001, 16'h0123}, 1'b0, f1, sw);
    check("overrun_set", 32'(overrun_o), 32'd1);
    check("overrun_valid_held", 32'(sample_valid_o), 32'd1);
    check("overrun_x_second", 32'(x_o), 32'h0456);
    check("overrun_y_second", 32'(y_o), 32'hFABC);
    sample_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("valid_clear_on_accept", 32'(sample_valid_o), 32'd0);
    check("overrun_sticky", 32'(overrun_o), 32'd1);

    // Enable drops mid-burst: sample still delivered, no further bursts
    do_burst(12'hFFF, 12'h7FF, 12'h800, 12'h456, {16'hFFFF, 16'h07FF, 16'hF800, 16'h0456}, 1'b1, f1, sw);
    lows = 0;
    repeat (2 * PERIOD) begin
      @(posedge clk_i); #1;
      if (!ncs_o) lows++;
    end
    check("idle_when_disabled", 32'(lows), 32'd0);
    enable_i = 1'b1;

    // Leave a sample pending, then reset during the 4th byte of the next burst
    sample_ready_i = 1'b0;
    do_burst(12'h0AA, 12'h055, 12'hF0F, 12'h800, {16'h00AA, 16'h0055, 16'hFF0F, 16'hF800}, 1'b0, f1, sw);
    check("pending_before_reset", 32'(sample_valid_o), 32'd1);
    wait_ncs(1'b0, "abort_burst_start", n);
    n = 0;
    while (mosi_log.size() < 4 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("reached_fourth_byte", 32'(mosi_log.size() >= 4), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_ncs", 32'(ncs_o), 32'd1);
    check("async_rst_valid", 32'(sample_valid_o), 32'd0);
    check("async_rst_overrun", 32'(overrun_o), 32'd0);
    check("async_rst_cyc", 32'(wb_cyc_o), 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;
    sample_ready_i = 1'b1;
    wait_first_access(n);
    do_burst(12'h321, 12'hC00, 12'h00F, 12'h8A0, {16'h0321, 16'hFC00, 16'h000F, 16'hF8A0}, 1'b0, f1, sw);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adxl362_reader.md
ADXL362_READER -- requirements
Module: adxl362_reader

Interface
REQ-001 SAMPLE_PERIOD, 100000: clk_i cycles between sample-burst starts; legal range 64..2^24-1.
REQ-002 SPCR_INIT, 8'h50: value written to simple_spi SPCR at init (SPE=1, MSTR=1, CPOL=0, CPHA=0, SPR=0).
REQ-003 clk_i  input  1  single system clock, shared with the Wishbone bus and simple_spi_top.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 enable_i  input  1  1 = periodic sampling runs; 0 = idle after the current burst.
REQ-006 wb_adr_o / wb_dat_o / wb_we_o / wb_cyc_o / wb_stb_o  output  2/8/1/1/1  Wishbone master to simple_spi_top (adr 0=SPCR, 1=SPSR, 2=SPDR).
REQ-007 wb_dat_i / wb_ack_i  input  8/1  Wishbone read data / ack from simple_spi_top.
REQ-008 ncs_o  output  1  ADXL362 chip select, active low.
REQ-009 x_o, y_o, z_o  output  16 each  sign-extended 12-bit acceleration samples.
REQ-010 temp_o  output  16  sign-extended 12-bit temperature (present only with ADXL362_READER_TEMP_EN).
REQ-011 sample_valid_o / sample_ready_i  output/input  1/1  sample handshake.
REQ-012 overrun_o  output  1  sticky flag: a new burst finished while the previous sample was still unaccepted.
REQ-013 busy_o  output  1  1 while ncs_o is low or init is in progress.

Function
REQ-014 Every Wishbone access SHALL assert cyc/stb together, hold adr/dat/we stable until wb_ack_i, and deassert both in the cycle after ack; there is one access in flight at most.
REQ-015 FSM states: INIT, WAIT, CS_ON, WR_BYTE, POLL, RD_BYTE, CS_OFF, each visited in this order; after CS_OFF the FSM returns to WAIT.
REQ-016 INIT: one write of SPCR_INIT to adr 0; then WAIT.
REQ-017 WAIT: 24-bit period counter; when it reaches SAMPLE_PERIOD-1 with enable_i=1, the counter SHALL reload 0 and the FSM SHALL enter CS_ON; with enable_i=0 the counter SHALL hold at 0.
REQ-018 CS_ON: ncs_o=0, then 2 idle cycles before the first byte.
REQ-019 Burst byte sequence: 0x0B (read cmd), 0x0E (XDATA_L addr), then 6 dummy 0x00 bytes (8 bytes in total).
REQ-020 For each byte: WR_BYTE writes the byte to adr 2; POLL reads adr 1 until bit0 (RFEMPTY)=0; RD_BYTE reads adr 2 and captures returned bytes 3..8 into a shadow register.
REQ-021 Shadow bytes are ordered XL,XH,YL,YH,ZL,ZH; each axis = {{4{H[3]}},H[3:0],L}.
REQ-022 CS_OFF: ncs_o=1 for at least 2 cycles. The shadow register SHALL then be copied to x_o/y_o/z_o and sample_valid_o SHALL be set in the same cycle.
REQ-023 sample_valid_o SHALL clear in the cycle after sample_valid_o && sample_ready_i; outputs SHALL stay stable while valid=1 and not accepted.
REQ-024 If a copy in CS_OFF happens while valid=1 and not accepted in that cycle, the outputs SHALL be overwritten with the new sample, valid SHALL stay 1, and overrun_o SHALL be set; overrun_o clears only on reset.
REQ-025 If acceptance and a new copy happen in the same cycle, there is no overrun and valid SHALL stay 1 with the new data.
REQ-026 enable_i falling mid-burst SHALL NOT abort the burst; the sample SHALL be delivered.

Reset
REQ-027 While rst_i=0: FSM=INIT, ncs_o=1, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, the sample outputs and shadow=0, sample_valid_o=0, overrun_o=0, busy_o=0, period counter=0.
REQ-028 Reset asserted mid-burst SHALL return ncs_o to 1 asynchronously; after release, INIT SHALL be repeated.

Configuration
REQ-029 Macro ADXL362_READER_TEMP_EN defined: the burst is 10 bytes (2 command bytes + 8 dummy bytes), TEMP_L/TEMP_H are captured after ZH, and temp_o exists and is updated with x/y/z; undefined: 8-byte burst, no temp_o port.

Verification
REQ-030 Reset release with simple_spi_top: the first WB access is a write adr 0, data 0x50; ncs_o stays 1 until the period expires.
REQ-031 SAMPLE_PERIOD=200, ADXL362 model X=0x123, Y=0xF00, Z=0x7FF -> x_o=0x0123, y_o=0xFF00, z_o=0x07FF with sample_valid_o=1; MOSI bytes are 0x0B,0x0E,0x00x6.
REQ-032 sample_ready_i held 1 -> one valid pulse per burst; bursts start every 200 cycles; overrun_o stays 0.
REQ-033 sample_ready_i held 0 across two bursts -> overrun_o=1, outputs show the second sample.
REQ-034 rst_i pulsed low during the 4th byte -> ncs_o=1 immediately, valid=0; after release INIT is repeated and the next sample is correct.
REQ-035 With ADXL362_READER_TEMP_EN, model temp=0x8A0 -> 10-byte burst, temp_o=0xF8A0.
